// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - command, load, ALU and debug signals of the operand sequencer
interface alu_operand_sequencer_if #(
  parameter int W = 32,
  parameter int A = 3
);
  logic         start;
  logic [A-1:0] src1;
  logic [A-1:0] src2;
  logic [A-1:0] dst;
  logic         ld_en;
  logic [A-1:0] ld_addr;
  logic [W-1:0] ld_data;
  logic [W-1:0] c_out;
  logic [W-1:0] R2;
  logic [W-1:0] R3;
  logic         busy;
  logic         done;
  logic [A-1:0] dbg_addr;
  logic [W-1:0] dbg_data;

  modport master (
    output start, src1, src2, dst, ld_en, ld_addr, ld_data, c_out, dbg_addr,
    input  R2, R3, busy, done, dbg_data
  );

  modport slave (
    input  start, src1, src2, dst, ld_en, ld_addr, ld_data, c_out, dbg_addr,
    output R2, R3, busy, done, dbg_data
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - register file, ALU operand driver and result write-back controller
module alu_operand_sequencer #(
  parameter int W       = 32,
  parameter int A       = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_operand_sequencer_if.slave  bus
);
  localparam int          N      = 1 << A;
  localparam logic [3:0]  LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

  state_t       r_state;
  logic [W-1:0] r_rf [N];
  logic [A-1:0] r_src1;
  logic [A-1:0] r_src2;
  logic [A-1:0] r_dst;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_r2;
  logic [W-1:0] r_r3;
  logic         r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src1  <= '0;
      r_src2  <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < N; i++) r_rf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Load commits at the same edge that accepts start, so FETCH sees it.
          if (bus.ld_en && (bus.ld_addr != '0)) r_rf[bus.ld_addr] <= bus.ld_data;
          if (bus.start) begin
            r_src1  <= bus.src1;
            r_src2  <= bus.src2;
            r_dst   <= bus.dst;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_r2    <= r_rf[r_src1];
          r_r3    <= r_rf[r_src2];
          r_cnt   <= LAT_M1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) r_state <= S_WB;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_WB: begin
          if (r_dst != '0) r_rf[r_dst] <= bus.c_out;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.R2       = r_r2;
  assign bus.R3       = r_r3;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : r_rf[bus.dbg_addr];
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - randomized and directed bench for two latency variants against a register-file model
module tb_alu_operand_sequencer;
  localparam int W = 32;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.W(W), .A(A)) bus_a ();
  alu_operand_sequencer_if #(.W(W), .A(A)) bus_b ();

  logic         start_v    [2];
  logic [A-1:0] src1_v     [2];
  logic [A-1:0] src2_v     [2];
  logic [A-1:0] dst_v      [2];
  logic         ld_en_v    [2];
  logic [A-1:0] ld_addr_v  [2];
  logic [W-1:0] ld_data_v  [2];
  logic [A-1:0] dbg_addr_v [2];
  logic [W-1:0] o_r2       [2];
  logic [W-1:0] o_r3       [2];
  logic [W-1:0] o_dbg      [2];
  logic         o_busy     [2];
  logic         o_done     [2];

  assign bus_a.start = start_v[0];    assign bus_b.start = start_v[1];
  assign bus_a.src1 = src1_v[0];      assign bus_b.src1 = src1_v[1];
  assign bus_a.src2 = src2_v[0];      assign bus_b.src2 = src2_v[1];
  assign bus_a.dst = dst_v[0];        assign bus_b.dst = dst_v[1];
  assign bus_a.ld_en = ld_en_v[0];    assign bus_b.ld_en = ld_en_v[1];
  assign bus_a.ld_addr = ld_addr_v[0]; assign bus_b.ld_addr = ld_addr_v[1];
  assign bus_a.ld_data = ld_data_v[0]; assign bus_b.ld_data = ld_data_v[1];
  assign bus_a.dbg_addr = dbg_addr_v[0]; assign bus_b.dbg_addr = dbg_addr_v[1];
  assign bus_a.c_out = bus_a.R2 | bus_a.R3;
  assign bus_b.c_out = bus_b.R2 | bus_b.R3;
  assign o_r2[0] = bus_a.R2;          assign o_r2[1] = bus_b.R2;
  assign o_r3[0] = bus_a.R3;          assign o_r3[1] = bus_b.R3;
  assign o_dbg[0] = bus_a.dbg_data;   assign o_dbg[1] = bus_b.dbg_data;
  assign o_busy[0] = bus_a.busy;      assign o_busy[1] = bus_b.busy;
  assign o_done[0] = bus_a.done;      assign o_done[1] = bus_b.done;

  alu_operand_sequencer #(.W(W), .A(A), .ALU_LAT(1)) u_dut_lat1 (.clk(clk), .rst(rst), .bus(bus_a));
  alu_operand_sequencer #(.W(W), .A(A), .ALU_LAT(4)) u_dut_lat4 (.clk(clk), .rst(rst), .bus(bus_b));

  int          lat [2] = '{1, 4};
  logic [31:0] m_rf [2][8];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_dbg(input int d, input int a);
    dbg_addr_v[d] = A'(a);
    #1;
    chk($sformatf("dbg_d%0d_r%0d", d, a), o_dbg[d], m_rf[d][a]);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m_rf[d][i] = '0;
  endtask

  task automatic do_load(input int d, input int a, input logic [31:0] v);
    ld_en_v[d] = 1'b1; ld_addr_v[d] = A'(a); ld_data_v[d] = v;
    @(posedge clk);
    if (a != 0) m_rf[d][a] = v;
    @(negedge clk);
    ld_en_v[d] = 1'b0;
    chk_dbg(d, a);
  endtask

  // Starts at a negedge, returns at the negedge of the done cycle.
  task automatic do_op(input int d, input int s1, input int s2, input int dd,
                       input bit ld, input int la, input logic [31:0] lv, input bit disturb);
    logic [31:0] e2, e3;
    int n;
    bit got;
    start_v[d] = 1'b1; src1_v[d] = A'(s1); src2_v[d] = A'(s2); dst_v[d] = A'(dd);
    if (ld) begin ld_en_v[d] = 1'b1; ld_addr_v[d] = A'(la); ld_data_v[d] = lv; end
    @(posedge clk);
    if (ld && la != 0) m_rf[d][la] = lv;
    e2 = m_rf[d][s1];
    e3 = m_rf[d][s2];
    @(negedge clk);
    start_v[d] = 1'b0; ld_en_v[d] = 1'b0;
    chk($sformatf("busy_after_start_d%0d", d), 32'(o_busy[d]), 32'd1);
    chk($sformatf("done_low_after_start_d%0d", d), 32'(o_done[d]), 32'd0);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk($sformatf("r2_fetch_d%0d", d), o_r2[d], e2);
        chk($sformatf("r3_fetch_d%0d", d), o_r3[d], e3);
      end
      if (disturb && n == 2) begin
        start_v[d] = 1'b1; src1_v[d] = A'($urandom_range(0, 7)); dst_v[d] = A'($urandom_range(1, 7));
        ld_en_v[d] = 1'b1; ld_addr_v[d] = A'($urandom_range(1, 7)); ld_data_v[d] = $urandom;
      end
      if (disturb && n == 3) begin start_v[d] = 1'b0; ld_en_v[d] = 1'b0; end
      if (o_done[d]) got = 1'b1;
    end
    start_v[d] = 1'b0; ld_en_v[d] = 1'b0;
    chk($sformatf("latency_d%0d", d), 32'(n), 32'(lat[d] + 2));
    chk($sformatf("busy_in_done_cycle_d%0d", d), 32'(o_busy[d]), 32'd0);
    chk($sformatf("r2_hold_d%0d", d), o_r2[d], e2);
    if (dd != 0) m_rf[d][dd] = e2 | e3;
    chk_dbg(d, dd);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 0; src1_v[d] = 0; src2_v[d] = 0; dst_v[d] = 0;
      ld_en_v[d] = 0; ld_addr_v[d] = 0; ld_data_v[d] = 0; dbg_addr_v[d] = 0;
    end
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 32'(o_busy[d]), 32'd0);
      chk("reset_done", 32'(o_done[d]), 32'd0);
      chk("reset_r2", o_r2[d], 32'd0);
      chk("reset_r3", o_r3[d], 32'd0);
    end
    rst = 1'b0;

    // Basic OR write-back on the 1-cycle ALU.
    do_load(0, 1, 32'h0000F0F0);
    do_load(0, 2, 32'h0F0F0000);
    do_op(0, 1, 2, 3, 0, 0, 0, 0);
    dbg_addr_v[0] = 3'd3; #1;
    chk("or_result_r3", o_dbg[0], 32'h0F0FF0F0);

    // Register 0 is hard-wired to zero.
    do_load(0, 0, 32'hFFFFFFFF);
    do_load(0, 1, 32'h00000001);
    do_op(0, 0, 1, 0, 0, 0, 0, 0);
    chk("r0_src_r2", o_r2[0], 32'd0);
    dbg_addr_v[0] = 3'd0; #1;
    chk("r0_stays_zero", o_dbg[0], 32'd0);

    // Same-cycle load and start with all indices equal.
    @(negedge clk);
    do_op(0, 5, 5, 5, 1, 5, 32'hA5A5A5A5, 0);
    chk("hazard_r2", o_r2[0], 32'hA5A5A5A5);
    chk("hazard_r3", o_r3[0], 32'hA5A5A5A5);
    dbg_addr_v[0] = 3'd5; #1;
    chk("hazard_r5", o_dbg[0], 32'hA5A5A5A5);

    // Back-to-back: next start issued in the done cycle.
    do_op(0, 5, 1, 6, 0, 0, 0, 0);
    do_op(0, 6, 3, 7, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_after_b2b", 32'(o_busy[0]), 32'd0);

    // Four-cycle ALU with start and load pulsed during EXEC.
    do_load(1, 1, 32'h12340000);
    do_load(1, 2, 32'h00005678);
    do_op(1, 1, 2, 3, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) chk_dbg(1, i);
    @(negedge clk);
    chk("ignored_start_d1", 32'(o_busy[1]), 32'd0);

    // Randomized operations and loads on both variants.
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 30; it++) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0)
          do_load(d, $urandom_range(0, 7), $urandom);
        else
          do_op(d, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom, ($urandom_range(0, 2) == 0));
        chk_dbg(d, $urandom_range(0, 7));
      end
    end

    // Reset mid-EXEC: operation abandoned, no write-back, no done.
    @(negedge clk);
    do_load(1, 4, 32'hDEADBEEF);
    start_v[1] = 1'b1; src1_v[1] = 3'd4; src2_v[1] = 3'd4; dst_v[1] = 3'd6;
    @(posedge clk); @(negedge clk);
    start_v[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk("midrst_busy", 32'(o_busy[d]), 32'd0);
      chk("midrst_done", 32'(o_done[d]), 32'd0);
      chk("midrst_r2", o_r2[d], 32'd0);
      chk("midrst_r3", o_r3[d], 32'd0);
      for (int i = 0; i < 8; i++) chk_dbg(d, i);
    end
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done[1] || o_busy[1]) seen++;
    end
    chk("midrst_no_writeback_activity", 32'(seen), 32'd0);
    chk_dbg(1, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
